// File: rtl/mfm_write_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_write_seq_if
//  Description : Payload-source and encode-FIFO bundle for the MFM record
//                sequencer.
//                  src_data/src_valid/src_ready  - host payload handshake
//                  encode_fifo_*                 - byte push into encoder FIFO
//                master : sequencer side (consumes payload, pushes FIFO)
//                slave  : environment side (offers payload, owns the FIFO)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mfm_write_seq_if;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       encode_fifo_full;
    logic [7:0] encode_fifo_wr_data;
    logic       encode_fifo_wr_mark;
    logic       encode_fifo_wr_done;
    logic       encode_fifo_we;

    modport master (
        input  src_data, src_valid, encode_fifo_full,
        output src_ready, encode_fifo_wr_data, encode_fifo_wr_mark,
               encode_fifo_wr_done, encode_fifo_we
    );

    modport slave (
        output src_data, src_valid, encode_fifo_full,
        input  src_ready, encode_fifo_wr_data, encode_fifo_wr_mark,
               encode_fifo_wr_done, encode_fifo_we
    );
endinterface
`default_nettype wire

// File: rtl/mfm_write_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_write_seq
//  Description : Builds one on-disk MFM record and pushes it byte by byte into
//                the encoder FIFO: pre-gap (0x4E), sync (0x00), three A1
//                address marks, mark byte, payload, CRC-16-CCITT, post-gap.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start, abort        - begin / terminate a record
//                rec_mark, rec_len   - record parameters, sampled on start
//                bus (master)        - payload source + encode FIFO push
//                start_writing       - writer enable, first push .. after done
//                busy, done          - sequencer active / end-of-record pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mfm_write_seq #(
    parameter int PRE_GAP_LEN  = 22,
    parameter int SYNC_LEN     = 12,
    parameter int POST_GAP_LEN = 24
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        abort,
    input  wire logic [7:0]  rec_mark,
    input  wire logic [9:0]  rec_len,
    mfm_write_seq_if.master  bus,
    output logic             start_writing,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_PRE_GAP  = 4'd1;
    localparam logic [3:0] c_SYNC     = 4'd2;
    localparam logic [3:0] c_AM       = 4'd3;
    localparam logic [3:0] c_MARK     = 4'd4;
    localparam logic [3:0] c_DATA     = 4'd5;
    localparam logic [3:0] c_CRC_HI   = 4'd6;
    localparam logic [3:0] c_CRC_LO   = 4'd7;
    localparam logic [3:0] c_POST_GAP = 4'd8;
    localparam logic [3:0] c_ABORT    = 4'd9;
    localparam logic [3:0] c_DONE     = 4'd10;

    localparam logic [9:0]  c_PRE_LEN  = 10'(PRE_GAP_LEN);
    localparam logic [9:0]  c_SYNC_LEN = 10'(SYNC_LEN);
    localparam logic [9:0]  c_POST_LEN = 10'(POST_GAP_LEN);
    localparam logic [9:0]  c_AM_LEN   = 10'd3;
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    logic [3:0]  r_state;
    logic [9:0]  r_cnt;
    logic [7:0]  r_mark;
    logic [9:0]  r_len;
    logic [15:0] r_crc;
    logic        r_start_writing;

    logic [3:0]  w_next_state;
    logic [9:0]  w_next_cnt;
    logic        w_emit;
    logic        w_we;
    logic        w_src_ready;
    logic [7:0]  w_wr_data;
    logic        w_wr_mark;
    logic        w_wr_done;
    logic        w_last;
    logic        w_crc_en;
    logic [15:0] w_crc_next;

    // One byte of CRC-16-CCITT (poly 0x1021), MSB first, unrolled in logic.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
        logic [15:0] v_crc;
        v_crc = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            v_crc = v_crc[15] ? ({v_crc[14:0], 1'b0} ^ 16'h1021)
                              : {v_crc[14:0], 1'b0};
        end
        return v_crc;
    endfunction

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_cnt           <= 10'd0;
            r_mark          <= 8'h00;
            r_len           <= 10'd0;
            r_crc           <= c_CRC_INIT;
            r_start_writing <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;

            if (r_state == c_IDLE && start) begin
                r_mark <= rec_mark;
                r_len  <= rec_len;
                r_crc  <= c_CRC_INIT;
            end else if (w_crc_en) begin
                r_crc  <= w_crc_next;
            end

            if (r_state == c_DONE)
                r_start_writing <= 1'b0;
            else if (w_we)
                r_start_writing <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: the count for a state is loaded on entry and the
    // state only moves on when its last byte actually transfers.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_PRE_GAP;
                    w_next_cnt   = c_PRE_LEN;
                end
            end
            c_PRE_GAP: begin
                if (w_we) begin
                    if (w_last) begin
                        w_next_state = c_SYNC;
                        w_next_cnt   = c_SYNC_LEN;
                    end else begin
                        w_next_cnt   = r_cnt - 10'd1;
                    end
                end
            end
            c_SYNC: begin
                if (w_we) begin
                    if (w_last) begin
                        w_next_state = c_AM;
                        w_next_cnt   = c_AM_LEN;
                    end else begin
                        w_next_cnt   = r_cnt - 10'd1;
                    end
                end
            end
            c_AM: begin
                if (w_we) begin
                    if (w_last) begin
                        w_next_state = c_MARK;
                        w_next_cnt   = 10'd1;
                    end else begin
                        w_next_cnt   = r_cnt - 10'd1;
                    end
                end
            end
            c_MARK: begin
                if (w_we) begin
                    if (r_len == 10'd0) begin
                        w_next_state = c_CRC_HI;
                        w_next_cnt   = 10'd1;
                    end else begin
                        w_next_state = c_DATA;
                        w_next_cnt   = r_len;
                    end
                end
            end
            c_DATA: begin
                if (w_we) begin
                    if (w_last) begin
                        w_next_state = c_CRC_HI;
                        w_next_cnt   = 10'd1;
                    end else begin
                        w_next_cnt   = r_cnt - 10'd1;
                    end
                end
            end
            c_CRC_HI: begin
                if (w_we) w_next_state = c_CRC_LO;
            end
            c_CRC_LO: begin
                if (w_we) begin
                    w_next_state = c_POST_GAP;
                    w_next_cnt   = c_POST_LEN;
                end
            end
            c_POST_GAP: begin
                if (w_we) begin
                    if (w_last) begin
                        w_next_state = c_DONE;
                        w_next_cnt   = 10'd0;
                    end else begin
                        w_next_cnt   = r_cnt - 10'd1;
                    end
                end
            end
            c_ABORT: begin
                if (w_we) w_next_state = c_DONE;
            end
            c_DONE: begin
                w_next_state = c_IDLE;
                w_next_cnt   = 10'd0;
            end
            default: begin
                w_next_state = c_IDLE;
                w_next_cnt   = 10'd0;
            end
        endcase

        // Abort overrides normal sequencing; ABORT itself is excluded so a
        // held abort level cannot emit more than one terminating byte.
        if (abort && r_state != c_IDLE && r_state != c_DONE &&
            r_state != c_ABORT) begin
            w_next_state = c_ABORT;
            w_next_cnt   = 10'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_emit      = (r_state != c_IDLE) && (r_state != c_DONE);
        w_last      = (r_cnt == 10'd1);
        w_src_ready = (r_state == c_DATA) && !bus.encode_fifo_full;
        w_we        = w_emit && !bus.encode_fifo_full &&
                      ((r_state != c_DATA) || bus.src_valid);
        w_wr_mark   = 1'b0;
        w_wr_done   = 1'b0;
        w_crc_en    = 1'b0;
        case (r_state)
            c_PRE_GAP:  w_wr_data = 8'h4E;
            c_SYNC:     w_wr_data = 8'h00;
            c_AM: begin
                w_wr_data = 8'hA1;
                w_wr_mark = 1'b1;
                w_crc_en  = w_we;
            end
            c_MARK: begin
                w_wr_data = r_mark;
                w_crc_en  = w_we;
            end
            c_DATA: begin
                w_wr_data = bus.src_data;
                w_crc_en  = w_we;
            end
            c_CRC_HI:   w_wr_data = r_crc[15:8];
            c_CRC_LO:   w_wr_data = r_crc[7:0];
            c_POST_GAP: begin
                w_wr_data = 8'h4E;
                w_wr_done = w_last;
            end
            c_ABORT: begin
                w_wr_data = 8'h4E;
                w_wr_done = 1'b1;
            end
            default:    w_wr_data = 8'h00;
        endcase
        w_crc_next = crc_step(r_crc, w_wr_data);
    end

    assign bus.encode_fifo_we      = w_we;
    assign bus.encode_fifo_wr_data = w_wr_data;
    assign bus.encode_fifo_wr_mark = w_wr_mark;
    assign bus.encode_fifo_wr_done = w_wr_done;
    assign bus.src_ready           = w_src_ready;
    assign start_writing           = r_start_writing;
    assign busy                    = (r_state != c_IDLE);
    assign done                    = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mfm_write_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfm_write_seq
//  Description : Directed self-checking bench for mfm_write_seq. Each record
//                is driven cycle by cycle against a bench-built byte stream
//                (bit-serial CRC model) with push/ready/flag checks per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mfm_write_seq;

    localparam int PRE  = 22;
    localparam int SYN  = 12;
    localparam int POST = 24;
    localparam int PL0  = PRE + SYN + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rec_mark = 8'h00;
    logic [9:0] rec_len = 10'd0;
    logic       start_writing;
    logic       busy;
    logic       done;

    mfm_write_seq_if bus ();

    mfm_write_seq #(
        .PRE_GAP_LEN  (PRE),
        .SYNC_LEN     (SYN),
        .POST_GAP_LEN (POST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .rec_mark      (rec_mark),
        .rec_len       (rec_len),
        .bus           (bus.master),
        .start_writing (start_writing),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pay [0:1023];
    logic [9:0]  exp_q [$];
    logic [15:0] cap_crc;
    int          nwr;
    int          ncyc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-16-CCITT reference
    function automatic logic [15:0] crc_bits(input logic [15:0] c,
                                             input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc_of(input logic [7:0] mark, input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 3; i++) c = crc_bits(c, 8'hA1);
        c = crc_bits(c, mark);
        for (int i = 0; i < len; i++) c = crc_bits(c, pay[i]);
        return c;
    endfunction

    task automatic run_record(input logic [7:0] mark, input int len,
                              input bit rnd_full, input bit rnd_valid,
                              input int abort_at, input int reset_at,
                              input int dup_at, input bit abort_with_start,
                              output int o_nwr, output int o_ncyc);
        logic [15:0] c;
        int          k;
        int          pidx;
        bit          aborted;
        bit          fin;
        bit          ppos;
        bit          abort_now;
        bit          exp_we;
        bit          timed_out;

        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back({2'b00, 8'h4E});
        for (int i = 0; i < SYN; i++) exp_q.push_back({2'b00, 8'h00});
        for (int i = 0; i < 3; i++)   exp_q.push_back({2'b01, 8'hA1});
        exp_q.push_back({2'b00, mark});
        for (int i = 0; i < len; i++) exp_q.push_back({2'b00, pay[i]});
        c = crc_of(mark, len);
        exp_q.push_back({2'b00, c[15:8]});
        exp_q.push_back({2'b00, c[7:0]});
        for (int i = 0; i < POST; i++)
            exp_q.push_back({(i == POST - 1), 1'b0, 8'h4E});

        o_nwr = 0; o_ncyc = 0; k = 0;
        aborted = 0; fin = 0; timed_out = 0;
        cap_crc = 16'h0000;

        @(negedge clk);
        start = 1'b1; abort = abort_with_start;
        rec_mark = mark; rec_len = 10'(len);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;

        while (!fin) begin
            ppos      = !aborted && (k >= PL0) && (k < PL0 + len);
            pidx      = k - PL0;
            abort_now = (abort_at >= 0) && ppos && (pidx == abort_at);
            bus.encode_fifo_full = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.src_valid = abort_now ? 1'b0 :
                            (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.src_data  = ppos ? pay[pidx] : 8'($urandom);
            abort = abort_now;
            start = (k == dup_at);

            if (k == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_we",   bus.encode_fifo_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_sw",   start_writing, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                reset = 1'b0;
                o_nwr = k;
                return;
            end

            #1;
            exp_we = !bus.encode_fifo_full && (aborted || !ppos || bus.src_valid);
            chk("we",        bus.encode_fifo_we, exp_we);
            chk("src_ready", bus.src_ready, ppos && !bus.encode_fifo_full);
            chk("busy",      busy, 1);
            chk("start_wr",  start_writing, (o_nwr > 0));
            chk("done_low",  done, 0);

            if (bus.encode_fifo_we) begin
                if (aborted) begin
                    chk("abort_byte", {bus.encode_fifo_wr_done,
                        bus.encode_fifo_wr_mark, bus.encode_fifo_wr_data}, 10'h24E);
                    fin = 1;
                end else begin
                    chk("byte", {bus.encode_fifo_wr_done, bus.encode_fifo_wr_mark,
                                 bus.encode_fifo_wr_data}, exp_q[k]);
                    if (k == PL0 + len)     cap_crc[15:8] = bus.encode_fifo_wr_data;
                    if (k == PL0 + len + 1) cap_crc[7:0]  = bus.encode_fifo_wr_data;
                    k++;
                    o_nwr++;
                    if (k == exp_q.size()) fin = 1;
                end
            end
            if (abort_now) aborted = 1;

            o_ncyc++;
            if (o_ncyc > 20000) begin
                checks++;
                errors++;
                $error("FAIL timeout observed=%0d writes expected=%0d", k, exp_q.size());
                timed_out = 1;
                fin = 1;
            end
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
        end

        bus.encode_fifo_full = 1'b0;
        bus.src_valid = 1'b0;
        if (!timed_out) begin
            #1;
            chk("done_pulse", done, 1);
            chk("done_sw",    start_writing, 1);
            chk("done_we",    bus.encode_fifo_we, 0);
            @(negedge clk);
            #1;
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_sw",   start_writing, 0);
            chk("idle_we",   bus.encode_fifo_we, 0);
        end
    endtask

    task automatic load_id_payload();
        pay[0] = 8'h00; pay[1] = 8'h00; pay[2] = 8'h01; pay[3] = 8'h02;
    endtask

    initial begin
        bus.src_data = 8'h00;
        bus.src_valid = 1'b0;
        bus.encode_fifo_full = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_we",    bus.encode_fifo_we, 0);
        chk("reset_busy",  busy, 0);
        chk("reset_done",  done, 0);
        chk("reset_sw",    start_writing, 0);
        chk("reset_ready", bus.src_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // Abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("idle_abort_busy", busy, 0);
        @(negedge clk);

        // ID record, unthrottled: every push on consecutive cycles
        load_id_payload();
        run_record(8'hFE, 4, 0, 0, -1, -1, -1, 0, nwr, ncyc);
        chk("id_writes", nwr, PRE + SYN + 4 + 4 + 2 + POST);
        chk("id_cycles", ncyc, PRE + SYN + 4 + 4 + 2 + POST);
        chk("id_crc",    cap_crc, 16'hCA6F);

        // 512-byte data record, src_valid dropping; a start mid-record is ignored
        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        run_record(8'hFB, 512, 0, 1, -1, -1, 200, 0, nwr, ncyc);
        chk("data_writes", nwr, PRE + SYN + 4 + 512 + 2 + POST);
        chk("data_crc",    cap_crc, crc_of(8'hFB, 512));

        // Same record with random FIFO backpressure
        run_record(8'hFB, 512, 1, 1, -1, -1, -1, 0, nwr, ncyc);
        chk("bp_writes", nwr, PRE + SYN + 4 + 512 + 2 + POST);
        chk("bp_crc",    cap_crc, crc_of(8'hFB, 512));

        // Zero-length record, start coincident with abort counts as start
        run_record(8'hFB, 0, 0, 0, -1, -1, -1, 1, nwr, ncyc);
        chk("zero_writes", nwr, PRE + SYN + 4 + 2 + POST);
        chk("zero_crc",    cap_crc, crc_of(8'hFB, 0));

        // Abort at payload byte 100
        for (int i = 0; i < 200; i++) pay[i] = 8'($urandom);
        run_record(8'hFB, 200, 0, 0, 100, -1, -1, 0, nwr, ncyc);
        chk("abort_writes", nwr, PL0 + 100);
        repeat (2) @(negedge clk);
        load_id_payload();
        run_record(8'hFE, 4, 0, 0, -1, -1, -1, 0, nwr, ncyc);
        chk("post_abort_crc", cap_crc, 16'hCA6F);

        // Reset in the middle of SYNC, then a complete record
        run_record(8'hFE, 4, 0, 0, -1, PRE + 5, -1, 0, nwr, ncyc);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_we",   bus.encode_fifo_we, 0);
        run_record(8'hFE, 4, 0, 0, -1, -1, -1, 0, nwr, ncyc);
        chk("post_rst_writes", nwr, PRE + SYN + 4 + 4 + 2 + POST);
        chk("post_rst_crc",    cap_crc, 16'hCA6F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
